adc_conversion_sequencer: RTL and testbench

ADC_CONVERSION_SEQUENCER -- requirements
Module: adc_conversion_sequencer

---
 rtl/adc_conversion_sequencer.sv | 112 +++++++++++
 tb/tb_adc_conversion_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_conversion_sequencer.sv
// Sequences ADC start strobes over a pixel window derived from the waveform counter.
// Supports pulse and toggle start styles, per-channel masking and sticky overrun flags.
module adc_conversion_sequencer #(
  parameter int CICLOS_FORMAS_DE_ONDA = 8,
  parameter int PRE_PIXELS            = 5,
  parameter int N_PIXELS              = 2048,
  parameter int N_CH                  = 1,
  parameter int CNT_W                 = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_contador,
  input  logic             i_mode,
  input  logic [N_CH-1:0]  i_ch_mask,
  input  logic [N_CH-1:0]  i_adc_busy,
  output logic [N_CH-1:0]  o_adc_start_conversion,
  output logic [15:0]      o_pixel_index,
  output logic             o_line_done,
  output logic [N_CH-1:0]  o_overrun
);

  localparam int PH_W = (CICLOS_FORMAS_DE_ONDA > 1) ? $clog2(CICLOS_FORMAS_DE_ONDA) : 1;
  localparam logic [CNT_W-1:0] WIN_LO   = CNT_W'(PRE_PIXELS * CICLOS_FORMAS_DE_ONDA);
  localparam logic [CNT_W-1:0] WIN_HI   = CNT_W'((PRE_PIXELS + N_PIXELS) * CICLOS_FORMAS_DE_ONDA);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CICLOS_FORMAS_DE_ONDA - 1);
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
  localparam logic [15:0]      IDX_LAST = 16'(N_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, DONE} state_t;

  state_t          state;
  state_t          next_state;
  logic [PH_W-1:0] phase;
  logic            mode_q;

  logic            in_window;
  logic            entering;
  logic            arming;
  logic            phase_wrap;
  logic            slot;
  logic            mode_change;
  logic [N_CH-1:0] eligible;
  logic [N_CH-1:0] pulse_req;

  assign in_window = (i_contador >= WIN_LO) && (i_contador < WIN_HI);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_enable)   next_state = ARMED;
      ARMED:   if (in_window)  next_state = ACTIVE;
      ACTIVE:  if (!in_window) next_state = DONE;
      DONE:    next_state = ARMED;
      default: next_state = IDLE;
    endcase
    if (!i_enable) next_state = IDLE;
  end

  assign entering    = (state == ARMED) && (next_state == ACTIVE);
  assign arming      = (state == IDLE) && (next_state == ARMED);
  assign phase_wrap  = (state == ACTIVE) && (phase == PH_LAST);
  assign slot        = entering || ((state == ACTIVE) && (phase == '0));
  assign mode_change = (i_mode != mode_q);

  // Dropping enable gates the channels on the same edge so no start leaks out.
  assign eligible  = {N_CH{i_enable && ((state == ARMED) || (state == ACTIVE)) && in_window}}
                     & i_ch_mask;
  assign pulse_req = eligible & {N_CH{slot}};

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state                  <= IDLE;
      phase                  <= '0;
      mode_q                 <= 1'b0;
      o_adc_start_conversion <= '0;
      o_pixel_index          <= '0;
      o_line_done            <= 1'b0;
      o_overrun              <= '0;
    end else begin
      state       <= next_state;
      mode_q      <= i_mode;
      o_line_done <= (next_state == DONE);

      if (entering)
        phase <= PH_ONE;
      else if ((state == ACTIVE) && (next_state == ACTIVE))
        phase <= phase_wrap ? '0 : phase + PH_ONE;
      else
        phase <= '0;

      if (entering)
        o_pixel_index <= '0;
      else if (phase_wrap && (o_pixel_index != IDX_LAST))
        o_pixel_index <= o_pixel_index + 16'd1;

      if (mode_change)
        o_adc_start_conversion <= '0;
      else if (i_mode)
        o_adc_start_conversion <= pulse_req & ~i_adc_busy;
      else
        o_adc_start_conversion <= eligible & ~o_adc_start_conversion;

      // Overrun only accumulates in pulse mode; toggle mode ignores busy.
      if (arming)
        o_overrun <= '0;
      else if (i_mode)
        o_overrun <= o_overrun | (pulse_req & i_adc_busy);
    end
  end

endmodule

// File: tb/tb_adc_conversion_sequencer.sv
// Scenario bench for adc_conversion_sequencer with a tiny window (5 pre, 4 pixels, 8 cycles).
// Expected output vectors {start, index, line_done, overrun} are queued per edge and compared after it.
module tb_adc_conversion_sequencer;

  logic        clock = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] contador;
  logic        mode;
  logic [1:0]  ch_mask;
  logic [1:0]  adc_busy;
  logic [1:0]  start;
  logic [15:0] pixel;
  logic        line_done;
  logic [1:0]  overrun;

  logic [20:0] sb[$];
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  adc_conversion_sequencer #(
    .CICLOS_FORMAS_DE_ONDA(8),
    .PRE_PIXELS(5),
    .N_PIXELS(4),
    .N_CH(2),
    .CNT_W(32)
  ) dut (
    .i_clock(clock),
    .i_reset(rst),
    .i_enable(enable),
    .i_contador(contador),
    .i_mode(mode),
    .i_ch_mask(ch_mask),
    .i_adc_busy(adc_busy),
    .o_adc_start_conversion(start),
    .o_pixel_index(pixel),
    .o_line_done(line_done),
    .o_overrun(overrun)
  );

  // Expected vector after the edge sampling contador c, for a pulse-mode line entered at 40.
  function automatic logic [20:0] line_exp(input int c, input logic [1:0] chans,
                                           input logic [15:0] hold);
    logic [1:0]  s;
    logic [15:0] ix;
    int          k;
    s = (c >= 40 && c <= 64 && (c % 8) == 0) ? chans : 2'b00;
    k = (c - 39) / 8;
    if (c < 40)      ix = hold;
    else if (c < 47) ix = 16'd0;
    else if (c < 72) ix = 16'((k > 3) ? 3 : k);
    else             ix = 16'd3;
    return {s, ix, (c == 72), 2'b00};
  endfunction

  task automatic tick(input int c);
    contador = 32'(c);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; contador = '0; adc_busy = 2'b00; ch_mask = 2'b11; mode = 1'b1;
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] exp_v, got;
    rst = 1'b1; enable = 1'b0; contador = '0; adc_busy = 2'b00; ch_mask = 2'b11; mode = 1'b1;
    #1;
    sb.push_back(21'd0);
    got = {start, pixel, line_done, overrun}; exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("[TB] FAIL reset_async got=%h exp=%h", got, exp_v); end
    do_reset();
    for (int i = 0; i < 7; i++) begin
      enable = (i >= 5);
      sb.push_back((i == 6) ? {2'b11, 16'd0, 1'b0, 2'b00} : 21'd0);
      tick(40);
      got = {start, pixel, line_done, overrun}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("[TB] FAIL reset_idle i=%0d got=%h exp=%h", i, got, exp_v); end
    end
  endtask

  task automatic test_pulse();
    logic [20:0] exp_v, got;
    do_reset(); enable = 1'b1;
    for (int c = 0; c <= 100; c++) begin
      sb.push_back(line_exp(c, 2'b11, 16'd0));
      tick(c);
      got = {start, pixel, line_done, overrun}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("[TB] FAIL pulse c=%0d got=%h exp=%h", c, got, exp_v); end
    end
  endtask

  task automatic test_toggle();
    logic [20:0] exp_v, got;
    do_reset(); mode = 1'b0; enable = 1'b1;
    for (int c = 0; c <= 100; c++) begin
      exp_v = line_exp(c, 2'b11, 16'd0);
      exp_v[20:19] = (c >= 40 && c <= 71 && ((c - 40) % 2) == 0) ? 2'b11 : 2'b00;
      sb.push_back(exp_v);
      tick(c);
      got = {start, pixel, line_done, overrun}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("[TB] FAIL toggle c=%0d got=%h exp=%h", c, got, exp_v); end
    end
  endtask

  task automatic test_busy();
    logic [20:0] exp_v, got;
    do_reset(); enable = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c <= ((p == 0) ? 100 : 72); c++) begin
        adc_busy = (p == 0 && c == 48) ? 2'b01 : 2'b00;
        exp_v = line_exp(c, 2'b11, (p == 0) ? 16'd0 : 16'd3);
        if (p == 0 && c == 48) exp_v[20:19] = 2'b10;
        exp_v[1:0] = (p == 1 || c >= 48) ? 2'b01 : 2'b00;
        sb.push_back(exp_v);
        tick(c);
        got = {start, pixel, line_done, overrun}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("[TB] FAIL busy p=%0d c=%0d got=%h exp=%h", p, c, got, exp_v); end
      end
    end
    adc_busy = 2'b00;
  endtask

  task automatic test_enable_drop();
    logic [20:0] exp_v, got;
    do_reset(); enable = 1'b1;
    for (int c = 0; c <= 100; c++) begin
      enable   = (c < 50 || c >= 90);
      adc_busy = (c == 48) ? 2'b11 : 2'b00;
      if (c < 50) begin
        exp_v = line_exp(c, 2'b11, 16'd0);
        if (c == 48) exp_v[20:19] = 2'b00;
        exp_v[1:0] = (c >= 48) ? 2'b11 : 2'b00;
      end else begin
        exp_v = {2'b00, 16'd1, 1'b0, (c >= 90) ? 2'b00 : 2'b11};
      end
      sb.push_back(exp_v);
      tick(c);
      got = {start, pixel, line_done, overrun}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("[TB] FAIL en_drop c=%0d got=%h exp=%h", c, got, exp_v); end
    end
    for (int c = 0; c <= 72; c++) begin
      sb.push_back(line_exp(c, 2'b11, 16'd1));
      tick(c);
      got = {start, pixel, line_done, overrun}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("[TB] FAIL en_relaunch c=%0d got=%h exp=%h", c, got, exp_v); end
    end
  endtask

  task automatic test_async_reset();
    logic [20:0] exp_v, got;
    do_reset(); enable = 1'b1;
    for (int c = 0; c <= 45; c++) begin
      adc_busy = (c == 40) ? 2'b11 : 2'b00;
      exp_v = line_exp(c, 2'b11, 16'd0);
      if (c == 40) exp_v[20:19] = 2'b00;
      exp_v[1:0] = (c >= 40) ? 2'b11 : 2'b00;
      sb.push_back(exp_v);
      tick(c);
      got = {start, pixel, line_done, overrun}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("[TB] FAIL areset_pre c=%0d got=%h exp=%h", c, got, exp_v); end
    end
    adc_busy = 2'b00;
    #2 rst = 1'b1; enable = 1'b0;
    #1;
    sb.push_back(21'd0);
    got = {start, pixel, line_done, overrun}; exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("[TB] FAIL areset_mid got=%h exp=%h", got, exp_v); end
    rst = 1'b0;
    for (int c = 46; c <= 100; c++) begin
      enable = (c >= 80);
      sb.push_back(21'd0);
      tick(c);
      got = {start, pixel, line_done, overrun}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("[TB] FAIL areset_quiet c=%0d got=%h exp=%h", c, got, exp_v); end
    end
    for (int c = 0; c <= 72; c++) begin
      sb.push_back(line_exp(c, 2'b11, 16'd0));
      tick(c);
      got = {start, pixel, line_done, overrun}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("[TB] FAIL areset_line c=%0d got=%h exp=%h", c, got, exp_v); end
    end
  endtask

  task automatic test_mask();
    logic [20:0] exp_v, got;
    do_reset(); ch_mask = 2'b10; enable = 1'b1;
    for (int c = 0; c <= 80; c++) begin
      sb.push_back(line_exp(c, 2'b10, 16'd0));
      tick(c);
      got = {start, pixel, line_done, overrun}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("[TB] FAIL mask c=%0d got=%h exp=%h", c, got, exp_v); end
    end
    ch_mask = 2'b11;
  endtask

  task automatic test_mode_switch();
    logic [20:0] exp_v, got;
    do_reset(); mode = 1'b0; enable = 1'b1;
    for (int c = 0; c <= 80; c++) begin
      mode  = (c >= 45);
      exp_v = line_exp(c, 2'b11, 16'd0);
      if (c < 45)
        exp_v[20:19] = (c >= 40 && ((c - 40) % 2) == 0) ? 2'b11 : 2'b00;
      else if (c == 45)
        exp_v[20:19] = 2'b00;
      sb.push_back(exp_v);
      tick(c);
      got = {start, pixel, line_done, overrun}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("[TB] FAIL mode_sw c=%0d got=%h exp=%h", c, got, exp_v); end
    end
  endtask

  task automatic test_skip_back();
    logic [20:0] exp_v, got;
    int cv, e, k;
    do_reset(); enable = 1'b1;
    for (int c = 0; c <= 52; c++) begin
      sb.push_back(line_exp(c, 2'b11, 16'd0));
      tick(c);
      got = {start, pixel, line_done, overrun}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("[TB] FAIL skip_pre c=%0d got=%h exp=%h", c, got, exp_v); end
    end
    // After the jump back the strobes keep their 8-edge cadence from window entry.
    for (int j = 0; j <= 39; j++) begin
      cv = 41 + j;
      e  = 13 + j;
      k  = (e + 1) / 8;
      exp_v = {(cv < 72 && (e % 8) == 0) ? 2'b11 : 2'b00, 16'((k > 3) ? 3 : k), (cv == 72), 2'b00};
      sb.push_back(exp_v);
      tick(cv);
      got = {start, pixel, line_done, overrun}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("[TB] FAIL skip c=%0d got=%h exp=%h", cv, got, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_pulse();
    test_toggle();
    test_busy();
    test_enable_drop();
    test_async_reset();
    test_mask();
    test_mode_switch();
    test_skip_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
